// File: rtl/rt_ibex_pcs_restore_seq.sv
// rt_ibex_pcs_restore_seq: writes a PCS LIFO restore vector back into the register file, one register per granted cycle
module rt_ibex_pcs_restore_seq #(
    parameter int unsigned NrSavedRegs = 9,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 5,
    parameter logic [NrSavedRegs-1:0][AddrWidth-1:0] RegAddrs =
        {5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8, 5'd1}
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  restore_en_i,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_i,
    input  logic                                  rf_wgnt_i,
    output logic                                  rf_we_o,
    output logic [AddrWidth-1:0]                  rf_waddr_o,
    output logic [DataWidth-1:0]                  rf_wdata_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  err_o
);

    localparam int unsigned     IdxW    = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NrSavedRegs - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

    state_e                                state_q, state_d;
    logic [IdxW-1:0]                       idx_q, idx_d;
    logic [NrSavedRegs-1:0][DataWidth-1:0] buf_q, buf_d;
    logic                                  busy_q, busy_d;
    logic                                  err_q, err_d;

    // Next state, buffer capture, index advance on grant, and write-port outputs
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        err_d      = 1'b0;
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (restore_en_i) begin
                    buf_d   = restore_data_i;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = RegAddrs[idx_q];
                rf_wdata_o = buf_q[idx_q];
                err_d      = restore_en_i;
                if (rf_wgnt_i) begin
                    if (idx_q == LastIdx) state_d = DONE;
                    else                  idx_d   = idx_q + IdxW'(1);
                end
            end
            DONE: begin
                done_o  = 1'b1;
                err_d   = restore_en_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, index, buffer and registered status flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_rt_ibex_pcs_restore_seq.sv
// tb_rt_ibex_pcs_restore_seq: scoreboard bench for the PCS restore write-back sequencer
module tb_rt_ibex_pcs_restore_seq;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             restore_en_i = 1'b0;
    logic [8:0][31:0] restore_data_i = '0;
    logic             rf_wgnt_i = 1'b1;
    logic             rf_we_o, busy_o, done_o, err_o;
    logic [4:0]       rf_waddr_o;
    logic [31:0]      rf_wdata_o;

    logic             en1 = 1'b0;
    logic [0:0][31:0] data1 = '0;
    logic             we1, busy1, done1, err1;
    logic [4:0]       waddr1;
    logic [31:0]      wdata1;

    int  cyc = 0;
    int  lo = 1, hi = 0;
    int  n_cmp = 0, n_fail = 0;
    wr_t wq[$], w1q[$];
    int  dq[$], eq[$], d1q[$];
    int  addrs[9] = '{1, 8, 9, 10, 11, 12, 13, 14, 15};

    rt_ibex_pcs_restore_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .restore_en_i(restore_en_i),
        .restore_data_i(restore_data_i), .rf_wgnt_i(rf_wgnt_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    rt_ibex_pcs_restore_seq #(.NrSavedRegs(1), .RegAddrs(5'd8)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .restore_en_i(en1),
        .restore_data_i(data1), .rf_wgnt_i(rf_wgnt_i),
        .rf_we_o(we1), .rf_waddr_o(waddr1), .rf_wdata_o(wdata1),
        .busy_o(busy1), .done_o(done1), .err_o(err1)
    );

    always #5 clk_i = ~clk_i;

    // Cycle counter: cycle N spans posedge N to posedge N+1
    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: compares DUT outputs against the queued expectations mid-cycle
    always @(negedge clk_i) begin
        if (cyc >= lo && cyc <= hi) begin
            n_cmp++;
            if (busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL busy c%0d: got %b want 1", cyc, busy_o);
            end
            if (rf_we_o) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_write c%0d: got x%0d=%h want none", cyc, rf_waddr_o, rf_wdata_o);
                end else begin
                    if (rf_waddr_o !== wq[0].addr || rf_wdata_o !== wq[0].data) begin
                        n_fail++;
                        $display("FAIL write c%0d: got x%0d=%h want x%0d=%h", cyc, rf_waddr_o, rf_wdata_o, wq[0].addr, wq[0].data);
                    end
                    if (rf_wgnt_i) begin
                        n_cmp++;
                        if (cyc != wq[0].cyc) begin
                            n_fail++;
                            $display("FAIL write_cycle: got c%0d want c%0d", cyc, wq[0].cyc);
                        end
                        void'(wq.pop_front());
                    end
                end
            end
        end else begin
            n_cmp++;
            if ({rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, done_o} !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs c%0d: got we=%b a=%0d d=%h busy=%b done=%b want all 0", cyc, rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, done_o);
            end
        end
        if (done_o) begin
            n_cmp++;
            if (dq.size() == 0 || dq[0] != cyc) begin
                n_fail++;
                $display("FAIL done c%0d: got pulse want %0d", cyc, dq.size() ? dq[0] : -1);
            end
            if (dq.size()) void'(dq.pop_front());
        end
        if (err_o) begin
            n_cmp++;
            if (eq.size() == 0 || eq[0] != cyc) begin
                n_fail++;
                $display("FAIL err c%0d: got pulse want %0d", cyc, eq.size() ? eq[0] : -1);
            end
            if (eq.size()) void'(eq.pop_front());
        end
        if (we1 && rf_wgnt_i) begin
            n_cmp++;
            if (w1q.size() == 0 || waddr1 !== w1q[0].addr || wdata1 !== w1q[0].data || cyc != w1q[0].cyc) begin
                n_fail++;
                $display("FAIL n1_write c%0d: got x%0d=%h want x%0d=%h c%0d", cyc, waddr1, wdata1,
                         w1q.size() ? w1q[0].addr : 5'd0, w1q.size() ? w1q[0].data : 32'd0, w1q.size() ? w1q[0].cyc : -1);
            end
            if (w1q.size()) void'(w1q.pop_front());
        end
        if (done1) begin
            n_cmp++;
            if (d1q.size() == 0 || d1q[0] != cyc) begin
                n_fail++;
                $display("FAIL n1_done c%0d: got pulse want %0d", cyc, d1q.size() ? d1q[0] : -1);
            end
            if (d1q.size()) void'(d1q.pop_front());
        end
    end

    // Issue one restore, queue its expected writes/done/err, and drive grant for dur cycles
    task automatic restore(input logic [31:0] base, input int slo, input int shi, input int ovl, input int dur);
        int c0, t;
        c0 = cyc;
        for (int i = 0; i < 9; i++) restore_data_i[i] = base + 32'(i);
        restore_en_i = 1'b1;
        rf_wgnt_i    = 1'b1;
        t = 1;
        for (int i = 0; i < 9; i++) begin
            while (t >= slo && t <= shi) t++;
            wq.push_back('{c0 + t, 5'(addrs[i]), base + 32'(i)});
            t++;
        end
        dq.push_back(c0 + t);
        lo = c0 + 1;
        hi = c0 + t;
        if (ovl > 0) eq.push_back(c0 + ovl + 1);
        for (int k = 1; k <= dur; k++) begin
            @(posedge clk_i); #1;
            restore_en_i = (k == ovl);
            if (k == ovl) for (int i = 0; i < 9; i++) restore_data_i[i] = 32'h5555_0000 + 32'(i);
            rf_wgnt_i = !(k >= slo && k <= shi);
        end
        restore_en_i = 1'b0;
        rf_wgnt_i    = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        idle(3);
        rst_ni = 1'b1;
        idle(2);
        restore(32'hA000_0000, 0, -1, 0, 11);
        idle(2);
        restore(32'hA000_0000, 3, 5, 0, 14);
        idle(2);
        restore(32'hB000_0000, 0, -1, 4, 11);
        restore(32'hC000_0000, 0, -1, 0, 11);
        idle(2);
        restore(32'hD000_0000, 0, -1, 0, 5);
        #1;
        rst_ni = 1'b0;
        hi = cyc - 1;
        wq.delete();
        dq.delete();
        idle(2);
        rst_ni = 1'b1;
        idle(4);
        restore(32'hE000_0000, 0, -1, 0, 11);
        idle(1);
        en1      = 1'b1;
        data1[0] = 32'hBEEF_0001;
        w1q.push_back('{cyc + 1, 5'd8, 32'hBEEF_0001});
        d1q.push_back(cyc + 2);
        idle(1);
        en1 = 1'b0;
        idle(4);
        n_cmp++;
        if (wq.size() || dq.size() || eq.size() || w1q.size() || d1q.size()) begin
            n_fail++;
            $display("FAIL leftover: got w=%0d d=%0d e=%0d w1=%0d d1=%0d want all 0", wq.size(), dq.size(), eq.size(), w1q.size(), d1q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
